pcie_read_scheduler: RTL and testbench
======================================

# pcie_read_scheduler

Sequences host-memory read requests for the DMA-to-FPGA path and tracks their completions as the PCIe RX parser delivers them. Splits a command (start address plus block count) into 512-byte memory read requests, assigns each a tag from a circular pool, and counts completion qwords per tag. It then releases finished blocks to the reorder-buffer consumer in issue order. Sits between the DMA command registers, the PCIe TX request path and the RX parser's completion outputs.

## Interface
- TAG_BITS, 5, width of the tag pool index; pool holds 2^TAG_BITS tags
- MAX_OUTSTANDING, 32, maximum issued-but-not-retired requests; 1..2^TAG_BITS
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_addr  in  55  start address bits [63:9] (512-byte aligned)
- cmd_count  in  16  number of 512-byte blocks; 0 is legal
- rreq_valid  out  1  read request pending to TX
- rreq_ready  in  1  TX takes request when rreq_valid && rreq_ready
- rreq_addr  out  55  request address bits [63:9]
- rreq_tag  out  8  {zeros, tag}; request length is always 128 DW
- completion_valid  in  1  one completion data qword from RX
- completion_tag  in  8  tag of that qword
- out_valid  out  1  oldest issued block fully received
- out_ready  in  1  consumer done with block; retire it
- out_tag  out  TAG_BITS  buffer slot of the oldest block
- busy  out  1  command active or any request outstanding
- error  out  1  sticky: completion for a non-outstanding tag, or a tag beyond 64 qwords

## Operation
- States: IDLE, RUN. IDLE: cmd_ready=1. On accept: addr<=cmd_addr, remaining<=cmd_count, error<=0, go to RUN. cmd_count=0 stays in IDLE.
- RUN: cmd_ready=0. rreq_valid=1 while remaining!=0 and outstanding<MAX_OUTSTANDING. On handshake: addr+=1, remaining-=1, wptr+=1, rcnt[wptr]<=0. Go to IDLE when remaining reaches 0; outstanding requests continue to retire in IDLE.
- rreq_addr/rreq_tag remain stable while rreq_valid && !rreq_ready.
- Tags are allocated circularly: wptr, rptr are TAG_BITS+1 bits; outstanding=wptr-rptr (modular). rreq_tag=wptr[TAG_BITS-1:0], upper bits zero.
- Completion beat: if completion_tag upper bits nonzero, or tag not within [rptr,wptr), or rcnt[tag]==64, set error and drop the beat. Otherwise rcnt[tag]+=1 (7-bit counter).
- out_valid = (outstanding!=0) && rcnt[rptr]==64. out_tag=rptr[TAG_BITS-1:0]. On out_valid && out_ready: rptr+=1.
- A request issued and a block retired in the same cycle: outstanding unchanged, both pointers advance.
- A completion beat to a tag in the same cycle that tag retires is impossible (rcnt==64), so it is flagged as error.
- busy = (state==RUN) || outstanding!=0.

## Timing
- Reset values: cmd_ready=1, rreq_valid=0, rreq_addr=0, rreq_tag=0, out_valid=0, out_tag=0, busy=0, error=0; wptr=rptr=0, all rcnt=0, state IDLE. Reset mid-operation discards all outstanding tags; completions arriving afterwards set error.
- cmd accept at edge N -> rreq_valid=1 in cycle N+1.
- rreq handshake at edge N -> next request valid in cycle N+1; one request per cycle sustained.
- Final (64th) completion beat sampled at edge N -> out_valid=1 in cycle N+1 if that tag is oldest.
- Retire at edge N -> out_valid reflects the next tag in cycle N+1; a freed slot is reissuable in cycle N+1 (rreq_valid may rise then).
- error sets one cycle after the offending beat.

## Structure
- Shared package pcie_pkg: QWORDS_PER_REQ=64, REQ_DW=128, BLOCK_SHIFT=9.
- Sub-module pcie_tag_counters: rcnt array, per-tag increment, clear-on-issue and full compare. The scheduler holds the FSM, pointers and handshakes.

## Test plan
- cmd_count=3, addr=0x100, rreq_ready=1 -> tags 0,1,2 on three consecutive cycles at addr 0x100,0x101,0x102; return to IDLE.
- MAX_OUTSTANDING=4, cmd_count=6, no completions -> exactly 4 requests issued. After 64 beats for tag 0 and one out_ready, tag 4 issues.
- Complete tag 1 fully before tag 0 -> out_valid stays 0 until tag 0 has 64 beats. Then out_tag 0, then 1 on consecutive retires.
- 65th beat to a tag, or beat with completion_tag=0x20 -> error=1 the next cycle, rcnt unchanged; cleared on the next cmd accept.
- Hold rreq_ready=0 for 5 cycles -> rreq_addr and rreq_tag stable, remaining unchanged.
- Reset asserted with 3 tags outstanding -> all outputs at reset values next cycle; a later beat for tag 1 sets error.

Source files
------------

// File: rtl/pcie_read_scheduler_pkg.sv
// Shared constants and types for the PCIe host-read scheduler.
// Each request fetches one 512-byte block (128 DW, 64 qwords).
package pcie_pkg;

    localparam int QWORDS_PER_REQ = 64;
    localparam int REQ_DW         = 128;
    localparam int BLOCK_SHIFT    = 9;
    localparam int CNT_BITS       = 7;
    localparam int TAG_FIELD_BITS = 8;
    localparam int ADDR_BITS      = 64 - BLOCK_SHIFT;
    localparam int COUNT_BITS     = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // A block is complete once every qword of its request has arrived.
    function automatic logic block_full(input logic [CNT_BITS-1:0] cnt);
        return cnt == CNT_BITS'(QWORDS_PER_REQ);
    endfunction

endpackage

// File: rtl/pcie_read_scheduler_if.sv
// Command, TX request, RX completion and consumer handshakes of the read scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface pcie_read_scheduler_if #(
    parameter int TAG_BITS = 5
);
    import pcie_pkg::*;

    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [ADDR_BITS-1:0]      cmd_addr;
    logic [COUNT_BITS-1:0]     cmd_count;
    logic                      rreq_valid;
    logic                      rreq_ready;
    logic [ADDR_BITS-1:0]      rreq_addr;
    logic [TAG_FIELD_BITS-1:0] rreq_tag;
    logic                      completion_valid;
    logic [TAG_FIELD_BITS-1:0] completion_tag;
    logic                      out_valid;
    logic                      out_ready;
    logic [TAG_BITS-1:0]       out_tag;
    logic                      busy;
    logic                      error;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_count, rreq_ready,
               completion_valid, completion_tag, out_ready,
        output cmd_ready, rreq_valid, rreq_addr, rreq_tag,
               out_valid, out_tag, busy, error
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_count, rreq_ready,
               completion_valid, completion_tag, out_ready,
        input  cmd_ready, rreq_valid, rreq_addr, rreq_tag,
               out_valid, out_tag, busy, error
    );

endinterface

// File: rtl/pcie_read_scheduler_tag_counters.sv
// Per-tag completion qword counters: cleared when a tag is issued, bumped per
// accepted completion beat, with full flags for the probed tag and the oldest tag.
module pcie_tag_counters
    import pcie_pkg::*;
#(
    parameter int TAG_BITS = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_en,
    input  logic [TAG_BITS-1:0] clear_tag,
    input  logic                inc_en,
    input  logic [TAG_BITS-1:0] inc_tag,
    input  logic [TAG_BITS-1:0] probe_tag,
    output logic                probe_full,
    input  logic [TAG_BITS-1:0] head_tag,
    output logic                head_full
);

    localparam int DEPTH = 1 << TAG_BITS;

    logic [CNT_BITS-1:0] rcnt_r [DEPTH];

    // Counter array update; an issued tag is never outstanding, so clear and
    // increment cannot target the same entry in one cycle.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                rcnt_r[i] <= '0;
            end else if (clear_en && (clear_tag == TAG_BITS'(i))) begin
                rcnt_r[i] <= '0;
            end else if (inc_en && (inc_tag == TAG_BITS'(i))) begin
                rcnt_r[i] <= rcnt_r[i] + 7'd1;
            end else begin
                rcnt_r[i] <= rcnt_r[i];
            end
        end
    end

    // Full compares for the completion being checked and the retire candidate.
    always_comb begin
        probe_full = block_full(rcnt_r[probe_tag]);
        head_full  = block_full(rcnt_r[head_tag]);
    end

endmodule

// File: rtl/pcie_read_scheduler.sv
// Splits DMA read commands into 512-byte tagged requests, validates completion
// beats against the outstanding tag window and retires finished blocks in issue order.
module pcie_read_scheduler
    import pcie_pkg::*;
#(
    parameter int TAG_BITS        = 5,
    parameter int MAX_OUTSTANDING = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    pcie_read_scheduler_if.slave   bus
);

    localparam logic [TAG_BITS:0] MAX_OUT_C = (TAG_BITS + 1)'(MAX_OUTSTANDING);

    sched_state_e           state_r;
    sched_state_e           state_next_s;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [COUNT_BITS-1:0]  remaining_r;
    logic [TAG_BITS:0]      wptr_r;
    logic [TAG_BITS:0]      rptr_r;
    logic [TAG_BITS:0]      outstanding_s;
    logic                   error_r;

    logic                   cmd_ready_s;
    logic                   rreq_valid_s;
    logic                   out_valid_s;
    logic                   accept_s;
    logic                   issue_s;
    logic                   retire_s;

    logic [TAG_BITS-1:0]    beat_tag_s;
    logic [TAG_BITS-1:0]    beat_offset_s;
    logic                   tag_upper_zero_s;
    logic                   in_window_s;
    logic                   beat_ok_s;
    logic                   beat_err_s;
    logic                   probe_full_s;
    logic                   head_full_s;

    // Pointers carry one wrap bit so a completely full pool is distinguishable from empty.
    assign outstanding_s = wptr_r - rptr_r;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: a zero-length command is accepted but never leaves IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (bus.cmd_count != 16'd0)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && (remaining_r == 16'd1)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: commands accepted only in IDLE, requests gated by tag credit.
    always_comb begin
        cmd_ready_s  = 1'b0;
        rreq_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmd_ready_s  = 1'b1;
                rreq_valid_s = 1'b0;
            end
            ST_RUN: begin
                cmd_ready_s  = 1'b0;
                rreq_valid_s = (remaining_r != 16'd0) && (outstanding_s < MAX_OUT_C);
            end
            default: begin
                cmd_ready_s  = 1'b0;
                rreq_valid_s = 1'b0;
            end
        endcase
    end

    // Handshake qualifiers and retire condition.
    always_comb begin
        out_valid_s = (outstanding_s != '0) && head_full_s;
        accept_s    = bus.cmd_valid && cmd_ready_s;
        issue_s     = rreq_valid_s && bus.rreq_ready;
        retire_s    = out_valid_s && bus.out_ready;
    end

    // Completion beat classification: tag must be in range, outstanding and not yet full.
    always_comb begin
        beat_tag_s       = bus.completion_tag[TAG_BITS-1:0];
        tag_upper_zero_s = (bus.completion_tag >> TAG_BITS) == 8'd0;
        beat_offset_s    = beat_tag_s - rptr_r[TAG_BITS-1:0];
        in_window_s      = {1'b0, beat_offset_s} < outstanding_s;
        if (bus.completion_valid) begin
            beat_ok_s  = tag_upper_zero_s && in_window_s && !probe_full_s;
            beat_err_s = !(tag_upper_zero_s && in_window_s && !probe_full_s);
        end else begin
            beat_ok_s  = 1'b0;
            beat_err_s = 1'b0;
        end
    end

    // Command address and remaining block count.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r      <= '0;
            remaining_r <= '0;
        end else if (accept_s) begin
            addr_r      <= bus.cmd_addr;
            remaining_r <= bus.cmd_count;
        end else if (issue_s) begin
            addr_r      <= addr_r + 55'd1;
            remaining_r <= remaining_r - 16'd1;
        end else begin
            addr_r      <= addr_r;
            remaining_r <= remaining_r;
        end
    end

    // Tag pool pointers; issue and retire may both advance in one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            wptr_r <= issue_s  ? wptr_r + 1'b1 : wptr_r;
            rptr_r <= retire_s ? rptr_r + 1'b1 : rptr_r;
        end
    end

    // Sticky error, cleared by the next accepted command unless a bad beat lands in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            error_r <= 1'b0;
        end else begin
            error_r <= beat_err_s || (error_r && !accept_s);
        end
    end

    pcie_tag_counters #(
        .TAG_BITS (TAG_BITS)
    ) u_tag_counters (
        .clock      (clock),
        .reset      (reset),
        .clear_en   (issue_s),
        .clear_tag  (wptr_r[TAG_BITS-1:0]),
        .inc_en     (beat_ok_s),
        .inc_tag    (beat_tag_s),
        .probe_tag  (beat_tag_s),
        .probe_full (probe_full_s),
        .head_tag   (rptr_r[TAG_BITS-1:0]),
        .head_full  (head_full_s)
    );

    assign bus.cmd_ready  = cmd_ready_s;
    assign bus.rreq_valid = rreq_valid_s;
    assign bus.rreq_addr  = addr_r;
    assign bus.rreq_tag   = TAG_FIELD_BITS'(wptr_r[TAG_BITS-1:0]);
    assign bus.out_valid  = out_valid_s;
    assign bus.out_tag    = rptr_r[TAG_BITS-1:0];
    assign bus.busy       = (state_r == ST_RUN) || (outstanding_s != '0);
    assign bus.error      = error_r;

endmodule

// File: tb/tb_pcie_read_scheduler.sv
// Bench for pcie_read_scheduler: directed scenarios then random traffic, all
// compared each cycle against a queue-of-blocks reference model.
module tb_pcie_read_scheduler;
    import pcie_pkg::*;

    localparam int TB_TAG_BITS = 5;
    localparam int NTAGS       = 32;
    localparam int MAXO        = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pcie_read_scheduler_if #(.TAG_BITS(TB_TAG_BITS)) bus ();

    pcie_read_scheduler #(
        .TAG_BITS        (TB_TAG_BITS),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int tag;
        int cnt;
    } blk_t;

    blk_t        q[$];
    bit          m_active;
    logic [54:0] m_addr;
    int          m_remaining;
    int          m_issued;
    int          m_retired;
    bit          m_error;
    int          checks   = 0;
    int          failures = 0;

    task automatic model_reset();
        q.delete();
        m_active    = 1'b0;
        m_addr      = '0;
        m_remaining = 0;
        m_issued    = 0;
        m_retired   = 0;
        m_error     = 1'b0;
    endtask

    function automatic bit e_rreq_valid();
        return m_active && (q.size() < MAXO);
    endfunction

    function automatic bit e_out_valid();
        return (q.size() > 0) && (q[0].cnt == 64);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at t=%0t", name, obs, expv, $time);
        end
    endtask

    task automatic check_outputs();
        chk("cmd_ready",  64'(bus.cmd_ready),  64'(!m_active));
        chk("rreq_valid", 64'(bus.rreq_valid), 64'(e_rreq_valid()));
        chk("rreq_addr",  64'(bus.rreq_addr),  64'(m_addr));
        chk("rreq_tag",   64'(bus.rreq_tag),   64'(m_issued % NTAGS));
        chk("out_valid",  64'(bus.out_valid),  64'(e_out_valid()));
        chk("out_tag",    64'(bus.out_tag),    64'(m_retired % NTAGS));
        chk("busy",       64'(bus.busy),       64'(m_active || (q.size() > 0)));
        chk("error",      64'(bus.error),      64'(m_error));
    endtask

    // Check current outputs, advance the model by one clock edge, then clock the DUT.
    task automatic step();
        bit   acc;
        bit   iss;
        bit   ret;
        bit   berr;
        int   t;
        int   idx;
        blk_t b;
        check_outputs();
        acc  = bus.cmd_valid && !m_active;
        iss  = bus.rreq_ready && e_rreq_valid();
        ret  = bus.out_ready && e_out_valid();
        berr = 1'b0;
        if (bus.completion_valid) begin
            t   = int'(bus.completion_tag);
            idx = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (q[i].tag == t) idx = i;
            end
            if (idx < 0 || q[idx].cnt == 64) berr = 1'b1;
            else q[idx].cnt = q[idx].cnt + 1;
        end
        if (ret) begin
            q.delete(0);
            m_retired++;
        end
        if (iss) begin
            b.tag = m_issued % NTAGS;
            b.cnt = 0;
            q.push_back(b);
            m_issued++;
            m_addr = m_addr + 55'd1;
            m_remaining--;
            if (m_remaining == 0) m_active = 1'b0;
        end
        m_error = berr || (m_error && !acc);
        if (acc) begin
            m_addr      = bus.cmd_addr;
            m_remaining = int'(bus.cmd_count);
            m_active    = (bus.cmd_count != 16'd0);
        end
        if (reset) model_reset();
        @(posedge clock);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send_cmd(input logic [54:0] a, input logic [15:0] n);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_count = n;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic beats(input int tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus.completion_valid = 1'b1;
            bus.completion_tag   = 8'(tag);
            step();
        end
        bus.completion_valid = 1'b0;
    endtask

    task automatic retire_all(input int n);
        bus.out_ready = 1'b1;
        run(n);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] rnd;
        int          r;
        int          idx;
        bus.cmd_valid        = 1'b0;
        bus.cmd_addr         = '0;
        bus.cmd_count        = '0;
        bus.rreq_ready       = 1'b0;
        bus.completion_valid = 1'b0;
        bus.completion_tag   = '0;
        bus.out_ready        = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
        run(2);

        // Three blocks back to back from 0x100.
        bus.rreq_ready = 1'b1;
        send_cmd(55'h100, 16'd3);
        run(4);
        beats(0, 64);
        beats(1, 64);
        beats(2, 64);
        retire_all(4);

        // Credit limit: six blocks, only four in flight until one retires.
        send_cmd(55'h200, 16'd6);
        run(6);
        beats(3, 64);
        retire_all(1);
        run(3);

        // Out-of-order completion holds retirement until the oldest block is full.
        beats(5, 64);
        run(3);
        beats(4, 64);
        retire_all(2);
        run(2);
        beats(6, 64);
        beats(7, 64);
        beats(8, 64);
        retire_all(4);

        // Overflow beat and out-of-range tag both flag error; a zero-length command clears it.
        send_cmd(55'h300, 16'd1);
        run(2);
        beats(9, 64);
        beats(9, 1);
        run(1);
        beats(32, 1);
        run(1);
        send_cmd(55'h10, 16'd0);
        run(1);
        retire_all(2);

        // Backpressure on the request path.
        bus.rreq_ready = 1'b0;
        send_cmd(55'h400, 16'd2);
        run(5);
        bus.rreq_ready = 1'b1;
        run(3);
        beats(10, 64);
        beats(11, 64);
        retire_all(3);

        // Reset with three blocks in flight; a late completion is then an error.
        send_cmd(55'h500, 16'd3);
        run(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(1);
        beats(1, 1);
        run(2);

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            rnd = {$urandom, $urandom};
            bus.cmd_valid  = ($urandom % 4) == 0;
            bus.cmd_addr   = rnd[54:0];
            bus.cmd_count  = 16'($urandom_range(0, 5));
            bus.rreq_ready = ($urandom % 4) != 0;
            bus.out_ready  = ($urandom % 3) != 0;
            r = int'($urandom % 100);
            if (r < 75 && q.size() > 0) begin
                idx = int'($urandom_range(0, q.size() - 1));
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].cnt < 64) begin
                        idx = i;
                        break;
                    end
                end
                if (($urandom % 50) == 0) idx = 0;
                bus.completion_valid = 1'b1;
                bus.completion_tag   = 8'(q[idx].tag);
            end else if (r < 78) begin
                bus.completion_valid = 1'b1;
                bus.completion_tag   = 8'($urandom_range(0, 255));
            end else begin
                bus.completion_valid = 1'b0;
            end
            reset = ($urandom % 600) == 0;
            step();
        end
        reset                = 1'b0;
        bus.completion_valid = 1'b0;
        bus.cmd_valid        = 1'b0;
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
